imem_loader: RTL
================

Name: imem_loader

Overview:
Instruction-memory front end that sits directly upstream of the core wrapper's instruction fetch port. It supplies the fetch-response data the wrapper consumes.
- A host stream loads a program image word-by-word through a valid/ready handshake.
- The block holds the core in reset while loading, then releases it.
- It serves fetches combinationally; any address outside the loaded image returns a RISC-V NOP.
- A restart pulse reloads a new program without a global reset.

Parameters:
DEPTH_LOG2, 10, log2 of memory depth in 32-bit words (1024 words).
HOLD_CYCLES, 4, cycles core_reset stays high after load completes (range 1..255).
NOP_WORD, 32'h00000013, word returned for out-of-image or invalid fetches.

Ports:
clock  input  1  single clock; all state updates on rising edge.
reset  input  1  asynchronous, active-low; 0 clears all state immediately.
ld_valid  input  1  host load word valid.
ld_ready  output  1  block accepts a load word this cycle.
ld_data  input  32  program word.
ld_last  input  1  marks the final word of the image; qualified by ld_valid.
ld_restart  input  1  one-cycle pulse; restarts loading (honoured in RUN only).
imem_req_addr  input  32  core fetch byte address.
imem_req_valid  input  1  core fetch valid.
imem_resp_data  output  32  fetch data, combinational from imem_req_addr.
core_reset  output  1  active-high reset to the core wrapper.
state  output  2  0=LOAD, 1=HOLD, 2=RUN.
load_count  output  DEPTH_LOG2+1  number of words in the current image.
err_overflow  output  1  sticky: memory filled before ld_last was seen.
fetch_fault  output  1  sticky: valid fetch was misaligned or beyond load_count.

Behaviour:
Reset values (reset low):
- state=LOAD, load_count=0, ld_ready=0, core_reset=1, err_overflow=0, fetch_fault=0, hold counter=0.
- Memory array is not cleared; load_count gates all reads.
- First cycle after reset deasserts: ld_ready=1.

LOAD:
- ld_ready=1; core_reset=1.
- On ld_valid&&ld_ready: mem[load_count]<=ld_data; load_count<=load_count+1.
- Accepted word with ld_last=1 -> HOLD.
- Accepted word written to index 2^DEPTH_LOG2-1 with ld_last=0 -> HOLD, err_overflow<=1.
- ld_valid with ld_ready=0 is never accepted; the host must keep the word stable until ld_ready.

HOLD:
- ld_ready=0; core_reset=1.
- Counter increments each cycle. When counter==HOLD_CYCLES-1 -> RUN and counter<=0.
- core_reset is therefore high for exactly HOLD_CYCLES cycles after the last accepted word's edge.

RUN:
- ld_ready=0; core_reset=0.
- ld_restart=1 -> LOAD at the next edge: load_count<=0, core_reset=1 from that edge.
- err_overflow and fetch_fault are cleared on that restart.
- ld_restart is ignored in LOAD and HOLD.

Fetch path (all states):
- idx = imem_req_addr[DEPTH_LOG2+1:2].
- imem_resp_data = mem[idx] only if state==RUN, addr[1:0]==0, addr[31:DEPTH_LOG2+2]==0 and idx<load_count; otherwise NOP_WORD.
- fetch_fault<=1 when state==RUN && imem_req_valid && (addr[1:0]!=0 || index out of range || idx>=load_count).
- A fault on the same cycle as ld_restart: the restart wins and fetch_fault ends cleared.
- No fetch of a word in the same cycle it is written is possible, since writes occur only in LOAD.

Widths:
- load_count saturates at 2^DEPTH_LOG2 and never wraps.
- The hold counter is 8 bits.

Reset mid-operation:
- Asserting reset in any state aborts the operation and returns to LOAD with load_count=0.
- A partial image becomes unreadable.

Test Plan:
1. Reset low 3 cycles then high; load 4 words {0x00100093,0x00200113,0x002081B3,0x0000006F}, ld_last on the 4th -> load_count=4, state=HOLD for exactly 4 cycles with core_reset=1, then RUN with core_reset=0.
2. In RUN, fetch addr 0x8 -> 0x002081B3; addr 0x10 (idx 4 >= load_count) -> 0x00000013 and fetch_fault=1; addr 0x6 -> NOP with fetch_fault=1.
3. Host asserts ld_valid continuously during HOLD and RUN -> ld_ready=0 and load_count stays unchanged; in LOAD, ld_valid gaps are inserted -> only handshaked words are written, in order.
4. DEPTH_LOG2=2; stream 5 words with no ld_last -> first 4 stored, err_overflow=1, state=HOLD, 5th word never accepted (ld_ready=0).
5. In RUN, pulse ld_restart in the same cycle as a faulting fetch -> next cycle state=LOAD, core_reset=1, load_count=0, fetch_fault=0; a reload of 2 words serves the new image.
6. Assert reset mid-load after 2 of 4 words -> immediate state=LOAD, load_count=0, core_reset=1; after release, fetch of addr 0x0 before completion returns 0x00000013.

Source files
------------

// File: rtl/imem_loader_if.sv
// Host load stream and core fetch port of the instruction-memory front end.
// The master side is the host/core; the slave side is the loader.
interface imem_loader_if;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        ld_restart;
  logic [31:0] imem_req_addr;
  logic        imem_req_valid;
  logic [31:0] imem_resp_data;

  modport master (
    output ld_valid, ld_data, ld_last, ld_restart, imem_req_addr, imem_req_valid,
    input  ld_ready, imem_resp_data
  );

  modport slave (
    input  ld_valid, ld_data, ld_last, ld_restart, imem_req_addr, imem_req_valid,
    output ld_ready, imem_resp_data
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction memory loader: streams a program image in, holds the core in
// reset for a fixed time, then serves combinational fetches until restarted.
module imem_loader #(
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter logic [31:0] NOP_WORD    = 32'h00000013
) (
  input  logic                clock,
  input  logic                reset,
  imem_loader_if.slave        bus,
  output logic                core_reset,
  output logic [1:0]          state,
  output logic [DEPTH_LOG2:0] load_count,
  output logic                err_overflow,
  output logic                fetch_fault
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_HOLD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [7:0]            hold_q, hold_d;
  logic                  overflow_q, overflow_d;
  logic                  fault_q, fault_d;

  logic [31:0]           mem [DEPTH];

  logic                  ld_ready;
  logic                  ld_fire;
  logic [31:0]           resp_data;
  logic [DEPTH_LOG2-1:0] wr_idx;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic                  addr_ok;
  logic                  fetch_hit;

  assign wr_idx    = count_q[DEPTH_LOG2-1:0];
  assign rd_idx    = bus.imem_req_addr[DEPTH_LOG2+1:2];
  assign addr_ok   = (bus.imem_req_addr[1:0] == 2'b00) &&
                     ((bus.imem_req_addr >> (DEPTH_LOG2 + 2)) == 32'd0);
  // load_count gates every read, so stale words from an older image stay hidden.
  assign fetch_hit = addr_ok && ({1'b0, rd_idx} < count_q);
  assign ld_fire   = bus.ld_valid && ld_ready;

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_LOAD;
      count_q    <= '0;
      hold_q     <= '0;
      overflow_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      hold_q     <= hold_d;
      overflow_q <= overflow_d;
      fault_q    <= fault_d;
    end
  end

  always_ff @(posedge clock) begin
    if (ld_fire) begin
      mem[wr_idx] <= bus.ld_data;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    hold_d     = hold_q;
    overflow_d = overflow_q;
    fault_d    = fault_q;
    case (state_q)
      ST_LOAD: begin
        if (ld_fire) begin
          count_d = count_q + 1'b1;
          if (bus.ld_last) begin
            state_d = ST_HOLD;
          end else if (wr_idx == {DEPTH_LOG2{1'b1}}) begin
            state_d    = ST_HOLD;
            overflow_d = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (hold_q == 8'(HOLD_CYCLES - 1)) begin
          state_d = ST_RUN;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      ST_RUN: begin
        // A restart outranks a fault raised in the same cycle.
        if (bus.ld_restart) begin
          state_d    = ST_LOAD;
          count_d    = '0;
          overflow_d = 1'b0;
          fault_d    = 1'b0;
        end else if (bus.imem_req_valid && !fetch_hit) begin
          fault_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  // Output logic; ld_ready is masked by reset so it is low while reset is held.
  always_comb begin
    ld_ready   = (state_q == ST_LOAD) && reset;
    core_reset = (state_q != ST_RUN);
    resp_data  = NOP_WORD;
    if (state_q == ST_RUN && fetch_hit) begin
      resp_data = mem[rd_idx];
    end
  end

  assign bus.ld_ready       = ld_ready;
  assign bus.imem_resp_data = resp_data;
  assign state              = state_q;
  assign load_count         = count_q;
  assign err_overflow       = overflow_q;
  assign fetch_fault        = fault_q;

endmodule
